clk_div_pll: RTL
================

# clk_div_pll

Parametrised multi-channel clock generator: it derives NUM_CLKS divided, phase-offset clocks from `refclk`, with a lock/settle sequence and a runtime reconfiguration handshake. It is the fabric-logic successor to the fixed two-output SDRAM PLL wrapper. It sits between the board reference clock and the memory and peripheral clock consumers, and provides per-channel divide ratio, phase offset, optional clock-enable strobes, and a `locked` flag with the same meaning as the PLL's.

## Interface
- NUM_CLKS, 2, number of output channels (1..8)
- DIV_W, 8, width of divide and phase fields
- LOCK_CYCLES, 16, settle time in refclk cycles before `locked` (>=1)
- DIV_INIT, {8'd4,8'd4}, packed NUM_CLKS*DIV_W reset divide ratios, channel 0 in the LSBs
- PHASE_INIT, {8'd1,8'd0}, packed NUM_CLKS*DIV_W reset phase delays in refclk cycles
- `refclk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `outclk`  out  NUM_CLKS  divided clocks, each driven from a flop
- `clken`  out  NUM_CLKS  one-cycle strobe marking each channel's period start
- `locked`  out  1  outputs valid and phase-aligned
- `cfg_valid`  in  1  reconfiguration request
- `cfg_ready`  out  1  request accepted this cycle when high together with `cfg_valid`
- `cfg_chan`  in  3  target channel
- `cfg_div`  in  DIV_W  new divide ratio
- `cfg_phase`  in  DIV_W  new phase delay
- `cfg_err`  out  1  one-cycle pulse: accepted request rejected as illegal

## Operation
- Per-channel registers: div[c], phase[c], cnt[c]. Reset loads div and phase from DIV_INIT and PHASE_INIT and clears cnt.
- FSM states:
  - SETTLE: entered on reset and after a legal reconfiguration. The settle counter counts 0..LOCK_CYCLES-1. `outclk`=0, `clken`=0, `locked`=0, `cfg_ready`=0. After the final count, the FSM moves to RUN.
  - RUN: `locked`=1, `cfg_ready`=1.
- On SETTLE->RUN, each cnt[c] loads (div[c]-phase[c]) mod div[c]. All channels therefore share a common time zero, and channel c's first rising edge comes phase[c] cycles after it.
- In RUN, cnt[c] increments each cycle and wraps div[c]-1 -> 0.
- In a RUN cycle with cnt[c]==k: outclk[c] = (k < div[c]>>1) and clken[c] = (k==0).
  - Odd div gives a low phase one cycle longer than the high phase.
- Handshake: a transfer occurs when cfg_valid && cfg_ready.
  - Legal request: cfg_chan < NUM_CLKS, cfg_div >= 2, cfg_phase < cfg_div. The target channel's registers update, the FSM enters SETTLE and the settle counter restarts. The other channels keep their div and phase but are re-aligned at the next SETTLE->RUN.
  - Illegal request: `cfg_err` pulses the next cycle, nothing else changes, and the FSM stays in RUN.
- Illegal DIV_INIT or PHASE_INIT values are not checked; the integrator is responsible.
- `rst` asserted in any state, including mid-settle or mid-period, forces SETTLE with reset values the next cycle. It also discards any request presented in that cycle.

## Timing
- All outputs are registered.
- Reset values: `outclk`=0, `clken`=0, `locked`=0, `cfg_ready`=0, `cfg_err`=0.
- After `rst` deasserts, `locked` rises exactly LOCK_CYCLES cycles later. In that same cycle each channel shows cnt = start value.
- Accepted legal request in cycle T:
  - `locked`, `cfg_ready` and `outclk` drop at T+1.
  - `locked` returns at T+1+LOCK_CYCLES.
- Accepted illegal request in cycle T: `cfg_err`=1 at T+1 only. `cfg_ready` stays 1.
- `cfg_*` may change freely while `cfg_ready`=0. The request is sampled only in the transfer cycle.

## Configuration
- `CLKDIV_CLKEN_OUT_EN`:
  - Defined: the `clken` strobes are generated as described.
  - Undefined: `clken` is tied to 0 and its logic is removed. The port remains, so instantiations do not change.

## Test plan
- Reset with defaults:
  - `locked` rises at cycle 16 after `rst` falls.
  - outclk[0] pattern is 1,1,0,0 repeating.
  - outclk[1] rises one cycle after outclk[0].
- Reconfiguration cfg_chan=0, cfg_div=5, cfg_phase=2:
  - `locked` is 0 for 16 cycles.
  - outclk[0] then has period 5 with high time 2, first rise 2 cycles after `locked`.
  - outclk[1] is re-aligned.
- Illegal requests cfg_div=1, then cfg_phase=6 with cfg_div=4, then cfg_chan=2:
  - Three single-cycle `cfg_err` pulses.
  - `locked` stays 1 and the outputs are undisturbed.
- `rst` pulsed mid-settle (cycle 7) and mid-RUN:
  - Outputs clear next cycle.
  - Full LOCK_CYCLES settle, reset values restored.
- With `CLKDIV_CLKEN_OUT_EN`: clken[0] is high exactly in cycles where cnt[0]==0 (every 4th cycle by default). Without the macro, `clken` is constant 0.
- Request held with `cfg_valid`=1 during SETTLE: not taken until `cfg_ready` rises. It is then accepted once, restarting settle.

Source files
------------

// File: rtl/clk_div_pll.sv
// Multi-channel divided/phase-offset clock generator with settle-then-lock sequencing
// and a valid/ready reconfiguration port. Optional clken strobes: CLKDIV_CLKEN_OUT_EN.
module clk_div_pll #(
    parameter int NUM_CLKS    = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CLKS*DIV_W-1:0] DIV_INIT   = {8'd4, 8'd4},
    parameter logic [NUM_CLKS*DIV_W-1:0] PHASE_INIT = {8'd1, 8'd0}
) (
    input  logic                refclk,
    input  logic                rst,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] clken,
    output logic                locked,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_chan,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [DIV_W-1:0]    cfg_phase,
    output logic                cfg_err
);

    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t                state_r;
    logic [SET_W-1:0]      settle_cnt_r;
    logic [DIV_W-1:0]      div_r   [NUM_CLKS];
    logic [DIV_W-1:0]      phase_r [NUM_CLKS];
    logic [DIV_W-1:0]      cnt_r   [NUM_CLKS];
    logic [NUM_CLKS-1:0]   outclk_r;
    logic                  locked_r;
    logic                  cfg_ready_r;
    logic                  cfg_err_r;

    logic [DIV_W-1:0]      cnt_next_s [NUM_CLKS];
    logic [DIV_W-1:0]      start_s    [NUM_CLKS];
    logic [NUM_CLKS-1:0]   wrap_s;
    logic                  req_legal_s;

    // Start count giving the channel its first rising edge phase cycles after time zero
    function automatic logic [DIV_W-1:0] start_count(input logic [DIV_W-1:0] div,
                                                     input logic [DIV_W-1:0] phase);
        logic [DIV_W-1:0] res;
        if (phase == '0) begin
            res = '0;
        end else begin
            res = div - phase;
        end
        return res;
    endfunction

    function automatic logic req_legal(input logic [2:0]       chan,
                                       input logic [DIV_W-1:0] div,
                                       input logic [DIV_W-1:0] phase);
        return ({1'b0, chan} < 4'(NUM_CLKS)) && (div >= DIV_W'(2)) && (phase < div);
    endfunction

    // Per-channel next count, wrap detect and settle-exit start values
    always_comb begin
        for (int c = 0; c < NUM_CLKS; c++) begin
            wrap_s[c] = (cnt_r[c] >= (div_r[c] - DIV_W'(1)));
            if (wrap_s[c]) begin
                cnt_next_s[c] = '0;
            end else begin
                cnt_next_s[c] = cnt_r[c] + DIV_W'(1);
            end
            start_s[c] = start_count(div_r[c], phase_r[c]);
        end
        req_legal_s = req_legal(cfg_chan, cfg_div, cfg_phase);
    end

    // Lock FSM, channel registers and registered clock outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= '0;
            locked_r     <= 1'b0;
            cfg_ready_r  <= 1'b0;
            cfg_err_r    <= 1'b0;
            outclk_r     <= '0;
            for (int c = 0; c < NUM_CLKS; c++) begin
                div_r[c]   <= DIV_INIT[c*DIV_W +: DIV_W];
                phase_r[c] <= PHASE_INIT[c*DIV_W +: DIV_W];
                cnt_r[c]   <= '0;
            end
        end else begin
            cfg_err_r <= 1'b0;
            case (state_r)
                ST_SETTLE: begin
                    outclk_r <= '0;
                    if (settle_cnt_r == SET_LAST) begin
                        state_r     <= ST_RUN;
                        locked_r    <= 1'b1;
                        cfg_ready_r <= 1'b1;
                        for (int c = 0; c < NUM_CLKS; c++) begin
                            cnt_r[c]    <= start_s[c];
                            outclk_r[c] <= (start_s[c] < (div_r[c] >> 1));
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SET_W'(1);
                    end
                end
                ST_RUN: begin
                    // cfg_ready is high throughout RUN, so cfg_valid alone marks a transfer
                    if (cfg_valid && req_legal_s) begin
                        state_r      <= ST_SETTLE;
                        settle_cnt_r <= '0;
                        locked_r     <= 1'b0;
                        cfg_ready_r  <= 1'b0;
                        outclk_r     <= '0;
                        for (int c = 0; c < NUM_CLKS; c++) begin
                            if (cfg_chan == 3'(c)) begin
                                div_r[c]   <= cfg_div;
                                phase_r[c] <= cfg_phase;
                            end else begin
                                div_r[c]   <= div_r[c];
                                phase_r[c] <= phase_r[c];
                            end
                        end
                    end else begin
                        cfg_err_r <= cfg_valid;
                        for (int c = 0; c < NUM_CLKS; c++) begin
                            cnt_r[c]    <= cnt_next_s[c];
                            outclk_r[c] <= (cnt_next_s[c] < (div_r[c] >> 1));
                        end
                    end
                end
                default: begin
                    state_r      <= ST_SETTLE;
                    settle_cnt_r <= '0;
                    locked_r     <= 1'b0;
                    cfg_ready_r  <= 1'b0;
                    outclk_r     <= '0;
                end
            endcase
        end
    end

`ifdef CLKDIV_CLKEN_OUT_EN
    logic [NUM_CLKS-1:0] clken_r;

    // Period-start strobes, aligned with the outclk edges above
    always_ff @(posedge refclk) begin
        if (rst) begin
            clken_r <= '0;
        end else if (state_r == ST_SETTLE) begin
            for (int c = 0; c < NUM_CLKS; c++) begin
                clken_r[c] <= (settle_cnt_r == SET_LAST) && (start_s[c] == '0);
            end
        end else if (cfg_valid && req_legal_s) begin
            clken_r <= '0;
        end else begin
            clken_r <= wrap_s;
        end
    end

    assign clken = clken_r;
`else
    assign clken = '0;
`endif

    assign outclk    = outclk_r;
    assign locked    = locked_r;
    assign cfg_ready = cfg_ready_r;
    assign cfg_err   = cfg_err_r;

endmodule
